// File: rtl/ha1588_tsq_drain.sv
// ha1588_tsq_drain: register-bus master that drains the ha1588 RX/TX
// timestamp queues onto a valid/ready stream. Option: HA1588_TSQ_DRAIN_CNT_EN.
module ha1588_tsq_drain #(
  parameter logic [7:0] RX_STAT_ADDR = 8'h40,
  parameter logic [7:0] TX_STAT_ADDR = 8'h60,
  parameter logic [7:0] Q_CTRL_ADDR  = 8'h3C,
  parameter logic [7:0] RX_DATA_ADDR = 8'h44,
  parameter logic [7:0] TX_DATA_ADDR = 8'h64,
  parameter int         RD_LAT       = 1,
  parameter int         POLL_GAP     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic         reg_wr,
  output logic         reg_rd,
  output logic [7:0]   reg_addr,
  output logic [31:0]  reg_wdata,
  input  logic [31:0]  reg_rdata,
  output logic         ts_valid,
  input  logic         ts_ready,
  output logic [127:0] ts_data,
  output logic         ts_dir,
  output logic         busy
`ifdef HA1588_TSQ_DRAIN_CNT_EN
  ,
  input  logic         cnt_clr,
  output logic [15:0]  rx_drained_cnt,
  output logic [15:0]  tx_drained_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    STAT_RD,
    STAT_WAIT,
    POP_WR,
    DATA_RD,
    DATA_WAIT,
    OUT,
    GAP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        ptr;
  logic [1:0]  streak;
  logic [1:0]  idx;
  logic [1:0]  lat_cnt;
  logic [15:0] gap_cnt;
  logic        lat_done;
  logic        gap_done;
  logic        q_empty;
  logic        in_wait;
  logic [7:0]  data_base;

  assign lat_done  = (lat_cnt == 2'(RD_LAT - 1));
  assign gap_done  = (gap_cnt == 16'(POLL_GAP - 1));
  assign q_empty   = (reg_rdata[7:0] == 8'h00);
  assign in_wait   = (state == STAT_WAIT) || (state == DATA_WAIT);
  assign data_base = ptr ? TX_DATA_ADDR : RX_DATA_ADDR;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and bus/stream outputs, decoded from the current state
  always_comb begin
    state_nx  = state;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    reg_addr  = 8'h00;
    reg_wdata = 32'h0;
    ts_valid  = 1'b0;
    ts_dir    = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) state_nx = STAT_RD;
      end
      STAT_RD: begin
        reg_rd   = 1'b1;
        reg_addr = ptr ? TX_STAT_ADDR : RX_STAT_ADDR;
        state_nx = STAT_WAIT;
      end
      STAT_WAIT: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (lat_done) begin
          if (!q_empty)
            state_nx = POP_WR;
          else if (streak == 2'd1 && POLL_GAP != 0)
            state_nx = GAP;
          else
            state_nx = IDLE;
        end
      end
      POP_WR: begin
        reg_wr    = 1'b1;
        reg_addr  = Q_CTRL_ADDR;
        reg_wdata = ptr ? 32'h2 : 32'h1;
        state_nx  = DATA_RD;
      end
      DATA_RD: begin
        reg_rd   = 1'b1;
        reg_addr = data_base + {4'd0, idx, 2'd0};
        state_nx = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (lat_done) state_nx = (idx == 2'd3) ? OUT : DATA_RD;
      end
      OUT: begin
        ts_valid = 1'b1;
        ts_dir   = ptr;
        if (ts_ready) state_nx = IDLE;
      end
      GAP: begin
        busy = 1'b0;
        if (!enable || gap_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // queue pointer, empty streak, word index and latency/gap counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 1'b0;
      streak  <= 2'd0;
      idx     <= 2'd0;
      lat_cnt <= 2'd0;
      gap_cnt <= 16'd0;
    end else begin
      lat_cnt <= (in_wait && state_nx == state) ? lat_cnt + 2'd1 : 2'd0;
      gap_cnt <= (state == GAP && state_nx == GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state == STAT_WAIT && enable && lat_done) begin
        if (q_empty) begin
          ptr    <= ~ptr;
          streak <= (streak == 2'd1) ? 2'd0 : streak + 2'd1;
        end else begin
          streak <= 2'd0;
        end
      end
      if (state == OUT && ts_ready) ptr <= ~ptr;
      if (state == POP_WR)
        idx <= 2'd0;
      else if (state == DATA_WAIT && lat_done)
        idx <= idx + 2'd1;
    end
  end

  // assemble the entry, word 0 in the top 32 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ts_data <= 128'h0;
    else if (state == DATA_WAIT && lat_done)
      ts_data[{~idx, 5'd0} +: 32] <= reg_rdata;
  end

`ifdef HA1588_TSQ_DRAIN_CNT_EN
  // saturating per-direction delivery counters, clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_drained_cnt <= 16'h0;
      tx_drained_cnt <= 16'h0;
    end else if (cnt_clr) begin
      rx_drained_cnt <= 16'h0;
      tx_drained_cnt <= 16'h0;
    end else if (ts_valid && ts_ready) begin
      if (ts_dir) begin
        if (tx_drained_cnt != 16'hFFFF)
          tx_drained_cnt <= tx_drained_cnt + 16'h1;
      end else begin
        if (rx_drained_cnt != 16'hFFFF)
          rx_drained_cnt <= rx_drained_cnt + 16'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ha1588_tsq_drain.sv
// tb_ha1588_tsq_drain: randomized queue contents against a transaction-level
// model of the drain rules; ha1588 register file emulated in the bench.
`timescale 1ns/1ps
module tb_ha1588_tsq_drain;
  localparam int RDL = 1;
  localparam int PG  = 64;
  localparam int PER = 2 + RDL + 1 + 4 * (RDL + 1) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         reg_wr;
  logic         reg_rd;
  logic [7:0]   reg_addr;
  logic [31:0]  reg_wdata;
  logic [31:0]  reg_rdata;
  logic         ts_valid;
  logic         ts_ready;
  logic [127:0] ts_data;
  logic         ts_dir;
  logic         busy;
`ifdef HA1588_TSQ_DRAIN_CNT_EN
  logic         cnt_clr;
  logic [15:0]  rx_cnt;
  logic [15:0]  tx_cnt;
`endif

  ha1588_tsq_drain #(
    .RD_LAT   (RDL),
    .POLL_GAP (PG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .ts_data   (ts_data),
    .ts_dir    (ts_dir),
    .busy      (busy)
`ifdef HA1588_TSQ_DRAIN_CNT_EN
    ,
    .cnt_clr        (cnt_clr),
    .rx_drained_cnt (rx_cnt),
    .tx_drained_cnt (tx_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          cyc;
  } strobe_t;

  typedef struct {
    logic         dir;
    logic [127:0] data;
    int           cyc;
  } deliv_t;

  strobe_t      slog[$];
  strobe_t      exp_s[$];
  deliv_t       dlog[$];
  deliv_t       exp_d[$];
  logic [127:0] rx_q[$];
  logic [127:0] tx_q[$];
  logic [127:0] cur_rx = '0;
  logic [127:0] cur_tx = '0;
  logic [31:0]  pipe [RDL];
  logic [7:0]   next_stat;
  int           cyc_n = 0;
  int           checks = 0;
  int           failures = 0;
  int           both_err = 0;
  int           idle_err = 0;
  bit           rnd_rdy = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] wrd(input logic [127:0] e, input int k);
    logic [127:0] t;
    t = e >> (32 * (3 - k));
    return t[31:0];
  endfunction

  function automatic logic [31:0] bus_val(input logic [7:0] a);
    if (a == 8'h40) return 32'(rx_q.size());
    if (a == 8'h60) return 32'(tx_q.size());
    if (a >= 8'h44 && a <= 8'h50) return wrd(cur_rx, (int'(a) - 'h44) / 4);
    if (a >= 8'h64 && a <= 8'h70) return wrd(cur_tx, (int'(a) - 'h64) / 4);
    return 32'hDEAD_BEEF;
  endfunction

  // bus/stream monitor and ha1588 register-file emulation
  initial begin
    strobe_t     s;
    deliv_t      d;
    logic [31:0] v;
    foreach (pipe[i]) pipe[i] = 32'h0;
    forever begin
      @(negedge clk);
      v = 32'h0;
      if (reg_rd && reg_wr) both_err++;
      if (!reg_rd && !reg_wr && (reg_addr != 8'h0 || reg_wdata != 32'h0))
        idle_err++;
      if (reg_rd || reg_wr) begin
        s.wr = reg_wr; s.addr = reg_addr; s.wdata = reg_wdata; s.cyc = cyc_n;
        slog.push_back(s);
      end
      if (reg_wr && reg_addr == 8'h3C) begin
        if (reg_wdata[0] && rx_q.size() > 0) cur_rx = rx_q.pop_front();
        if (reg_wdata[1] && tx_q.size() > 0) cur_tx = tx_q.pop_front();
      end
      if (reg_rd) v = bus_val(reg_addr);
      for (int i = RDL - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = v;
      if (ts_valid && ts_ready) begin
        d.dir = ts_dir; d.data = ts_data; d.cyc = cyc_n;
        dlog.push_back(d);
      end
    end
  end

  // read data appears RDL cycles after the strobe cycle
  initial begin
    reg_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      reg_rdata = pipe[RDL-1];
    end
  end

  task automatic chk(input string tag, input logic [167:0] obs,
                     input logic [167:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rnd_rdy) ts_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input int nrx, input int ntx);
    rx_q.delete();
    tx_q.delete();
    for (int i = 0; i < nrx; i++)
      rx_q.push_back({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < ntx; i++)
      tx_q.push_back({$urandom, $urandom, $urandom, $urandom});
  endtask

  // expected strobe/delivery sequence from the drain rules, up to the first gap
  task automatic build_exp();
    logic [127:0] mq0[$];
    logic [127:0] mq1[$];
    logic [127:0] e;
    int           p;
    int           st;
    int           n;
    strobe_t      s;
    deliv_t       d;
    mq0 = rx_q;
    mq1 = tx_q;
    p = 0;
    st = 0;
    exp_s.delete();
    exp_d.delete();
    forever begin
      s.wr = 1'b0; s.wdata = 32'h0; s.cyc = 0;
      s.addr = (p != 0) ? 8'h60 : 8'h40;
      exp_s.push_back(s);
      n = (p != 0) ? mq1.size() : mq0.size();
      if (n == 0) begin
        p = 1 - p;
        st++;
        if (st == 2) break;
      end else begin
        st = 0;
        if (p != 0) e = mq1.pop_front();
        else        e = mq0.pop_front();
        s.wr = 1'b1; s.addr = 8'h3C; s.wdata = (p != 0) ? 32'h2 : 32'h1;
        exp_s.push_back(s);
        for (int k = 0; k < 4; k++) begin
          s.wr = 1'b0; s.wdata = 32'h0;
          s.addr = 8'(((p != 0) ? 'h64 : 'h44) + 4 * k);
          exp_s.push_back(s);
        end
        d.dir = 1'(p); d.data = e; d.cyc = 0;
        exp_d.push_back(d);
        p = 1 - p;
      end
    end
    next_stat = (p != 0) ? 8'h60 : 8'h40;
  endtask

  task automatic run_scn(input int nrx, input int ntx, input bit rnd,
                         input bit per);
    bit found;
    int n;
    rst = 1'b1;
    enable = 1'b0;
    rnd_rdy = 1'b0;
    ts_ready = 1'(!rnd);
    cyc();
    cyc();
    fill(nrx, ntx);
    build_exp();
    slog.delete();
    dlog.delete();
    both_err = 0;
    idle_err = 0;
    rnd_rdy = rnd;
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (slog.size() >= exp_s.size()) break;
      cyc();
    end
    n = exp_s.size();
    chk("strobe_count", slog.size(), n);
    for (int k = 0; k < n && k < slog.size(); k++)
      chk($sformatf("strobe[%0d]", k),
          {slog[k].wr, slog[k].addr, slog[k].wdata},
          {exp_s[k].wr, exp_s[k].addr, exp_s[k].wdata});
    chk("deliv_count", dlog.size(), exp_d.size());
    for (int k = 0; k < exp_d.size() && k < dlog.size(); k++)
      chk($sformatf("deliv[%0d]", k), {dlog[k].dir, dlog[k].data},
          {exp_d[k].dir, exp_d[k].data});
    if (per)
      for (int k = 1; k < dlog.size(); k++)
        chk("entry_period", dlog[k].cyc - dlog[k-1].cyc, PER);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (slog.size() > n) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("gap_end_seen", found, 1'b1);
    if (found) begin
      chk("gap_len", slog[n].cyc - slog[n-1].cyc, RDL + PG + 2);
      chk("gap_next_addr", {slog[n].wr, slog[n].addr}, {1'b0, next_stat});
    end
    chk("strobe_exclusive", both_err, 0);
    chk("quiet_bus", idle_err, 0);
    enable = 1'b0;
    rnd_rdy = 1'b0;
    cyc();
  endtask

  initial begin
    bit           found;
    logic [127:0] e;
    rst = 1'b1;
    enable = 1'b0;
    ts_ready = 1'b0;
`ifdef HA1588_TSQ_DRAIN_CNT_EN
    cnt_clr = 1'b0;
`endif
    cyc();
    cyc();
    chk("rst_reg_wr", reg_wr, 1'b0);
    chk("rst_reg_rd", reg_rd, 1'b0);
    chk("rst_reg_addr", reg_addr, 8'h0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);
    chk("rst_ts_valid", ts_valid, 1'b0);
    chk("rst_ts_data", ts_data, 128'h0);
    chk("rst_ts_dir", ts_dir, 1'b0);
    chk("rst_busy", busy, 1'b0);

    run_scn(1, 0, 1'b0, 1'b0);
    run_scn(3, 3, 1'b0, 1'b1);

    // backpressure: hold ready low while the entry is offered
    rst = 1'b1; enable = 1'b0; ts_ready = 1'b0;
    cyc();
    cyc();
    fill(1, 0);
    e = rx_q[0];
    slog.delete();
    dlog.delete();
    rst = 1'b0;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (ts_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_reach_out", found, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", ts_valid, 1'b1);
      chk("bp_data", ts_data, e);
      chk("bp_dir", ts_dir, 1'b0);
      chk("bp_no_strobe", slog.size(), 6);
      cyc();
    end
    @(posedge clk);
    #2;
    ts_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_deliv_count", dlog.size(), 1);
    if (dlog.size() > 0)
      chk("bp_deliv", {dlog[0].dir, dlog[0].data}, {1'b0, e});
    cyc();
    chk("bp_valid_drop", ts_valid, 1'b0);
    enable = 1'b0;
    cyc();

    // enable dropped in DATA_WAIT of word 1
    rst = 1'b1; ts_ready = 1'b1;
    cyc();
    cyc();
    fill(2, 0);
    e = rx_q[0];
    slog.delete();
    dlog.delete();
    rst = 1'b0;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (reg_rd && reg_addr == 8'h48) begin
        found = 1'b1;
        break;
      end
    end
    chk("en_reach_w1", found, 1'b1);
    @(posedge clk);
    #2;
    enable = 1'b0;
    repeat (40) cyc();
    chk("en_strobe_count", slog.size(), 6);
    if (slog.size() > 0)
      chk("en_last_addr", slog[$].addr, 8'h50);
    chk("en_deliv_count", dlog.size(), 1);
    if (dlog.size() > 0)
      chk("en_deliv", {dlog[0].dir, dlog[0].data}, {1'b0, e});
    chk("en_idle_busy", busy, 1'b0);

    // asynchronous reset while in DATA_RD
    rst = 1'b1;
    cyc();
    cyc();
    fill(1, 0);
    rst = 1'b0;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (reg_rd && reg_addr == 8'h44) begin
        found = 1'b1;
        break;
      end
    end
    chk("ar_reach_data", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_reg_rd", reg_rd, 1'b0);
    chk("ar_reg_wr", reg_wr, 1'b0);
    chk("ar_reg_addr", reg_addr, 8'h0);
    chk("ar_reg_wdata", reg_wdata, 32'h0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_ts_valid", ts_valid, 1'b0);
    chk("ar_ts_dir", ts_dir, 1'b0);
    cyc();
    slog.delete();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (slog.size() > 0) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("ar_restart_seen", found, 1'b1);
    if (found)
      chk("ar_first_strobe", {slog[0].wr, slog[0].addr}, {1'b0, 8'h40});
    enable = 1'b0;
    cyc();

    for (int r = 0; r < 3; r++)
      run_scn($urandom_range(0, 4), $urandom_range(0, 4), 1'b1, 1'b0);

`ifdef HA1588_TSQ_DRAIN_CNT_EN
    run_scn(2, 1, 1'b0, 1'b0);
    chk("cnt_rx", rx_cnt, 16'd2);
    chk("cnt_tx", tx_cnt, 16'd1);
    fill(1, 0);
    ts_ready = 1'b1;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (ts_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("clr_reach_out", found, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #2;
    cnt_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("clr_rx", rx_cnt, 16'd0);
    chk("clr_tx", tx_cnt, 16'd0);
    enable = 1'b0;
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
